write_enable_sequencer: RTL and testbench
=========================================

WRITE_ENABLE_SEQUENCER -- requirements
Module: write_enable_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-002 Parameter DATA_W, default 4, SHALL be the data width in bits.
REQ-003 Parameter NUM_EN, default 8, SHALL be the number of enable outputs.
REQ-004 Parameter DEPTH, default 4, SHALL be the FIFO depth; it SHALL be a power of two.
REQ-005 Parameter GAP, default 1, SHALL be the number of idle cycles between issued writes; 0 SHALL be legal.
REQ-006 Port: clk, input, 1, clock; all state SHALL update on its rising edge.
REQ-007 Port: rst, input, 1, synchronous active-high reset.
REQ-008 Port: in_valid, input, 1, write request present.
REQ-009 Port: in_ready, output, 1, FIFO can accept a request.
REQ-010 Port: in_data, input, DATA_W, write data.
REQ-011 Port: in_sel, input, clog2(NUM_EN), target enable index.
REQ-012 Port: en, output, NUM_EN, one-hot write-enable pulses to the downstream register bank.
REQ-013 Port: d_in, output, DATA_W, data presented with en.
REQ-014 Port: busy, output, 1, high when the FIFO is non-empty or the state is not IDLE.
REQ-015 Port: fifo_count, output, clog2(DEPTH)+1, number of queued entries.

Function
REQ-016 A request SHALL be accepted on the cycle when in_valid and in_ready are both high; {in_sel, in_data} SHALL then be pushed.
REQ-017 in_ready SHALL be high exactly when fifo_count < DEPTH; it SHALL be registered and SHALL NOT depend combinationally on in_valid.
REQ-018 The FSM SHALL have three states: IDLE, ISSUE and GAP_WAIT.
REQ-019 IDLE to ISSUE SHALL occur when the FIFO is non-empty, with a pop on that same edge.
REQ-020 In ISSUE, en SHALL have exactly bit sel set for one cycle, and d_in SHALL equal the popped data.
REQ-021 After ISSUE, the FSM SHALL enter GAP_WAIT for GAP cycles. If GAP=0 it SHALL go directly to ISSUE when the FIFO is non-empty, otherwise to IDLE.
REQ-022 When the GAP counter expires, GAP_WAIT SHALL go to ISSUE (with a pop) when the FIFO is non-empty, otherwise to IDLE.
REQ-023 Outside ISSUE, en SHALL be all zeros and d_in SHALL hold its last issued value.
REQ-024 Latency from acceptance into an empty, idle block to the en pulse SHALL be 2 cycles (push edge, then pop edge; en is high in the following cycle).
REQ-025 On a simultaneous push and pop, fifo_count SHALL be unchanged; a push while full SHALL NOT occur because in_ready is low.
REQ-026 FIFO read and write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO.
REQ-027 If in_sel >= NUM_EN, the entry SHALL be popped and consume its ISSUE slot with en all zeros (dropped, not stalled).

Reset
REQ-028 While rst is high, on each clk edge: state SHALL be IDLE, pointers and fifo_count SHALL be 0, en SHALL be 0, d_in SHALL be 0, and busy SHALL be 0.
REQ-029 in_ready SHALL be 0 while rst is high and SHALL become 1 on the first edge after rst falls.
REQ-030 Asserting rst mid-ISSUE or mid-GAP_WAIT SHALL discard all queued entries, and no en pulse SHALL appear in the cycle after the reset edge.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, DATA_W/NUM_EN defaults and the entry struct {sel, data}.
REQ-032 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and DEPTH; the FSM and GAP counter SHALL live in the top module.

Verification
REQ-033 Reset, then a single write of sel=3, data=0xA -> en=8'b0000_1000 with d_in=0xA, exactly 2 cycles after acceptance, for one cycle only.
REQ-034 With GAP=1, back-to-back writes sel=0..7 with data=sel -> en bits 0..7 pulse in order, one idle cycle between pulses, and d_in tracks the data.
REQ-035 Five pushes with DEPTH=4 while the block is held in GAP_WAIT -> in_ready drops at fifo_count=4 and the fifth request is accepted only after a pop.
REQ-036 A write with sel=9 (NUM_EN=8, 4-bit sel) -> no en bit set, the entry is consumed, and the following entry issues normally.
REQ-037 rst asserted during ISSUE with 3 entries queued -> en=0, fifo_count=0, busy=0 next cycle, and no further pulses.
REQ-038 GAP=0 with continuous valid input -> one en pulse every cycle in steady state, and fifo_count stays constant under simultaneous push and pop.

Source files
------------

// File: rtl/write_enable_sequencer_pkg.sv
// Shared types and defaults for the write-enable sequencer: FSM state encoding
// and the queued {sel, data} entry layout.
package write_enable_sequencer_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_NUM_EN = 8;
    localparam int DEF_SEL_W  = $clog2(DEF_NUM_EN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        GAP_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_SEL_W-1:0]  sel;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/write_enable_sequencer_fifo.sv
// Synchronous FIFO with power-of-two depth; pointers wrap naturally and the
// head entry is presented combinationally on rdata.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/write_enable_sequencer.sv
// Queues {sel, data} write requests and replays them as one-hot enable pulses,
// spacing issued writes by GAP idle cycles.
module write_enable_sequencer
    import write_enable_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_EN = DEF_NUM_EN,
    parameter int DEPTH  = 4,
    parameter int GAP    = 1,
    parameter int SEL_W  = $clog2(NUM_EN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [NUM_EN-1:0]       en,
    output logic [DATA_W-1:0]       d_in,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t                   state;
    logic [GW-1:0]            gap_cnt;
    logic                     push;
    logic                     pop;
    logic                     can_issue;
    logic [SEL_W+DATA_W-1:0]  head;
    logic [SEL_W-1:0]         head_sel;
    logic [CW-1:0]            count_nxt;

    sync_fifo #(.WIDTH(SEL_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_sel, in_data}),
        .rdata (head),
        .count (fifo_count)
    );

    assign head_sel  = head[SEL_W+DATA_W-1:DATA_W];
    assign push      = in_valid && in_ready;
    // With GAP=0 the slot after an issue is immediately available again.
    assign can_issue = (state == IDLE) || (state == ISSUE && GAP == 0) ||
                       (state == GAP_WAIT && gap_cnt == '0);
    assign pop       = can_issue && (fifo_count != '0);
    assign count_nxt = fifo_count + CW'(push) - CW'(pop);
    assign busy      = (fifo_count != '0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            en       <= '0;
            d_in     <= '0;
            in_ready <= 1'b0;
        end else begin
            in_ready <= count_nxt < CW'(DEPTH);
            en       <= '0;
            if (pop) begin
                state <= ISSUE;
                d_in  <= head[DATA_W-1:0];
                // Out-of-range targets still burn their slot, just silently.
                if (32'(head_sel) < NUM_EN) en <= NUM_EN'(1) << head_sel;
            end else begin
                case (state)
                    ISSUE: begin
                        if (GAP == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP_WAIT;
                            gap_cnt <= GW'(GAP - 1);
                        end
                    end
                    GAP_WAIT: begin
                        if (gap_cnt == '0) state <= IDLE;
                        else               gap_cnt <= gap_cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_write_enable_sequencer.sv
// Bench for write_enable_sequencer: a GAP=1 and a GAP=0 instance share stimulus
// and are compared every cycle against a pop-time arithmetic reference model.
module tb_write_enable_sequencer;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [3:0]      in_data = 4'd0;
    logic [3:0]      in_sel = 4'd0;
    logic [1:0]      rdy;
    logic [1:0]      busy_o;
    logic [1:0][7:0] en_o;
    logic [1:0][3:0] d_o;
    logic [1:0][2:0] cnt_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    write_enable_sequencer #(.DATA_W(4), .NUM_EN(8), .DEPTH(4), .GAP(1), .SEL_W(4)) ua (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .in_sel(in_sel), .en(en_o[0]), .d_in(d_o[0]), .busy(busy_o[0]), .fifo_count(cnt_o[0])
    );

    write_enable_sequencer #(.DATA_W(4), .NUM_EN(8), .DEPTH(4), .GAP(0), .SEL_W(4)) ub (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .in_sel(in_sel), .en(en_o[1]), .d_in(d_o[1]), .busy(busy_o[1]), .fifo_count(cnt_o[1])
    );

    // Reference model: an entry may leave the queue at edge c only if the
    // previous departure was more than GAP edges earlier.
    int              cyc = 0;
    int              q [2][64];
    int              hd [2] = '{0, 0};
    int              tl [2] = '{0, 0};
    int              lastp [2] = '{-1000, -1000};
    logic [1:0][7:0] m_en = '0;
    logic [1:0][3:0] m_d = '0;
    logic [1:0]      m_rdy = '0;
    logic [1:0]      m_busy = '0;

    always @(posedge clk) begin : model
        int c, nh, nt, e, lp, g;
        logic [7:0] en_n;
        logic [3:0] d_n;
        c = cyc + 1;
        cyc <= c;
        for (int k = 0; k < 2; k++) begin
            g = (k == 0) ? 1 : 0;
            if (rst) begin
                hd[k] <= 0; tl[k] <= 0; lastp[k] <= -1000;
                m_en[k] <= '0; m_d[k] <= '0; m_rdy[k] <= 1'b0; m_busy[k] <= 1'b0;
            end else begin
                nh = hd[k]; nt = tl[k]; lp = lastp[k];
                en_n = '0; d_n = m_d[k];
                if (nt > nh && c - lp > g) begin
                    e = q[k][nh % 64];
                    nh++;
                    lp = c;
                    d_n = e[3:0];
                    if (e / 16 < 8) en_n = 8'd1 << (e / 16);
                end
                if (in_valid && m_rdy[k]) begin
                    q[k][nt % 64] <= int'({in_sel, in_data});
                    nt++;
                end
                hd[k] <= nh; tl[k] <= nt; lastp[k] <= lp;
                m_en[k] <= en_n; m_d[k] <= d_n;
                m_rdy[k] <= (nt - nh) < 4;
                m_busy[k] <= (nt > nh) || (c - lp <= g);
            end
        end
    end

    function automatic logic [33:0] obs_dut();
        return {rdy[1], en_o[1], d_o[1], busy_o[1], cnt_o[1],
                rdy[0], en_o[0], d_o[0], busy_o[0], cnt_o[0]};
    endfunction

    function automatic logic [33:0] obs_mdl();
        logic [2:0] c1, c0;
        c1 = 3'(tl[1] - hd[1]);
        c0 = 3'(tl[0] - hd[0]);
        return {m_rdy[1], m_en[1], m_d[1], m_busy[1], c1,
                m_rdy[0], m_en[0], m_d[0], m_busy[0], c0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sel = 4'd1; in_data = 4'd2;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({rdy, en_o, d_o, busy_o, cnt_o} !== 34'd0)
                $display("FAIL reset_state got=%h want=0", {rdy, en_o, d_o, busy_o, cnt_o});
            else passes++;
        end
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy !== 2'b11) $display("FAIL ready_after_reset got=%b want=11", rdy);
        else passes++;
        checks++;
        if (obs_dut() !== obs_mdl())
            $display("FAIL model_reset cyc=%0d got=%h want=%h", cyc, obs_dut(), obs_mdl());
        else passes++;
    endtask

    task automatic test_single();
        logic [7:0] want;
        in_valid = 1'b1; in_sel = 4'd3; in_data = 4'hA;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            want = (i == 2) ? 8'h08 : 8'h00;
            checks++;
            if (en_o[0] !== want || (i == 2 && d_o[0] !== 4'hA))
                $display("FAIL single_pulse i=%0d got en=%h d=%h want en=%h d=a", i, en_o[0], d_o[0], want);
            else passes++;
            checks++;
            if (obs_dut() !== obs_mdl())
                $display("FAIL model_single cyc=%0d got=%h want=%h", cyc, obs_dut(), obs_mdl());
            else passes++;
        end
    endtask

    task automatic test_sweep();
        int nxt = 0, pulses = 0, last_t = -1;
        logic acc;
        in_valid = 1'b1; in_sel = 4'd0; in_data = 4'd0;
        for (int t = 0; t < 40; t++) begin
            acc = in_valid && m_rdy[0];
            @(negedge clk);
            checks++;
            if (obs_dut() !== obs_mdl())
                $display("FAIL model_sweep cyc=%0d got=%h want=%h", cyc, obs_dut(), obs_mdl());
            else passes++;
            if (en_o[0] !== 8'd0) begin
                checks++;
                if (en_o[0] !== 8'(1 << pulses) || d_o[0] !== 4'(pulses) ||
                    (pulses > 0 && t - last_t != 2))
                    $display("FAIL sweep_order n=%0d got en=%h d=%h spacing=%0d want en=%h d=%0d spacing=2",
                             pulses, en_o[0], d_o[0], t - last_t, 8'(1 << pulses), pulses);
                else passes++;
                pulses++;
                last_t = t;
            end
            if (acc) begin
                nxt++;
                in_sel = 4'(nxt); in_data = 4'(nxt);
                if (nxt == 8) in_valid = 1'b0;
            end
        end
        checks++;
        if (pulses != 8) $display("FAIL sweep_count got=%0d want=8", pulses);
        else passes++;
    endtask

    task automatic test_full();
        int pushed = 0;
        logic [2:0] max_cnt = 3'd0;
        logic acc;
        in_valid = 1'b1; in_sel = 4'($urandom_range(7)); in_data = 4'($urandom);
        for (int t = 0; t < 40; t++) begin
            acc = in_valid && m_rdy[0];
            @(negedge clk);
            checks++;
            if (obs_dut() !== obs_mdl())
                $display("FAIL model_full cyc=%0d got=%h want=%h", cyc, obs_dut(), obs_mdl());
            else passes++;
            if (cnt_o[0] > max_cnt) max_cnt = cnt_o[0];
            if (tl[0] - hd[0] == 4) begin
                checks++;
                if (rdy[0] !== 1'b0) $display("FAIL full_ready got=%b want=0", rdy[0]);
                else passes++;
            end
            if (acc) begin
                pushed++;
                in_sel = 4'($urandom_range(7)); in_data = 4'($urandom);
                if (pushed == 9) in_valid = 1'b0;
            end
        end
        checks++;
        if (max_cnt !== 3'd4) $display("FAIL full_max_count got=%0d want=4", max_cnt);
        else passes++;
    endtask

    task automatic test_bad_sel();
        int pulses = 0, pushed = 0;
        logic acc;
        in_valid = 1'b1; in_sel = 4'd9; in_data = 4'd5;
        for (int t = 0; t < 16; t++) begin
            acc = in_valid && m_rdy[0];
            @(negedge clk);
            checks++;
            if (obs_dut() !== obs_mdl())
                $display("FAIL model_badsel cyc=%0d got=%h want=%h", cyc, obs_dut(), obs_mdl());
            else passes++;
            if (en_o[0] !== 8'd0) begin
                pulses++;
                checks++;
                if (en_o[0] !== 8'h04 || d_o[0] !== 4'd6)
                    $display("FAIL badsel_next got en=%h d=%h want en=04 d=6", en_o[0], d_o[0]);
                else passes++;
            end
            if (acc) begin
                pushed++;
                in_sel = 4'd2; in_data = 4'd6;
                if (pushed == 2) in_valid = 1'b0;
            end
        end
        checks++;
        if (pulses != 1 || cnt_o[0] !== 3'd0)
            $display("FAIL badsel_consumed got pulses=%0d cnt=%0d want pulses=1 cnt=0", pulses, cnt_o[0]);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        logic acc;
        in_valid = 1'b1; in_sel = 4'($urandom_range(7)); in_data = 4'($urandom);
        for (int t = 0; t < 30 && !found; t++) begin
            acc = in_valid && m_rdy[0];
            @(negedge clk);
            checks++;
            if (obs_dut() !== obs_mdl())
                $display("FAIL model_rstmid cyc=%0d got=%h want=%h", cyc, obs_dut(), obs_mdl());
            else passes++;
            if (acc) begin
                in_sel = 4'($urandom_range(7)); in_data = 4'($urandom);
            end
            if (tl[0] - hd[0] == 3 && m_en[0] != 8'd0) found = 1;
        end
        checks++;
        if (!found) $display("FAIL rstmid_setup got=no_issue_with_3_queued want=found");
        else passes++;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (en_o[0] !== 8'd0 || cnt_o[0] !== 3'd0 || busy_o[0] !== 1'b0)
            $display("FAIL rstmid_clear got en=%h cnt=%0d busy=%b want 0 0 0", en_o[0], cnt_o[0], busy_o[0]);
        else passes++;
        rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            checks++;
            if (en_o !== 16'd0 || obs_dut() !== obs_mdl())
                $display("FAIL rstmid_quiet cyc=%0d got=%h want=%h", cyc, obs_dut(), obs_mdl());
            else passes++;
        end
    endtask

    task automatic test_gap0_stream();
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            in_sel = 4'($urandom_range(7)); in_data = 4'($urandom);
            if (t >= 30) in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (obs_dut() !== obs_mdl())
                $display("FAIL model_gap0 cyc=%0d got=%h want=%h", cyc, obs_dut(), obs_mdl());
            else passes++;
            if (t >= 2 && t < 30) begin
                checks++;
                if (en_o[1] == 8'd0 || cnt_o[1] !== 3'd1)
                    $display("FAIL gap0_stream t=%0d got en=%h cnt=%0d want en!=0 cnt=1", t, en_o[1], cnt_o[1]);
                else passes++;
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            in_valid = ($urandom_range(3) != 0);
            in_sel   = 4'($urandom_range(15));
            in_data  = 4'($urandom);
            rst      = (t < 385) && ($urandom_range(60) == 0);
            if (t >= 385) in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (obs_dut() !== obs_mdl())
                $display("FAIL model_random cyc=%0d got=%h want=%h", cyc, obs_dut(), obs_mdl());
            else passes++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_full();
        test_bad_sel();
        test_reset_mid();
        test_gap0_stream();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
